// File: rtl/mulacc_dot_master.sv
// Avalon-MM master that drives the fp32 multiply-accumulate slave to compute
// acc = bias + sum(a[i]*b[i]) over a stream of len operand pairs.
module mulacc_dot_master #(
    parameter int LEN_W        = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      bias,
    input  logic             pair_valid,
    output logic             pair_ready,
    input  logic [31:0]      pair_a,
    input  logic [31:0]      pair_b,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic [1:0]       avm_address,
    output logic             avm_write,
    output logic [31:0]      avm_writedata,
    output logic             avm_read,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_waitrequest
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_WR_A    = 3'd2;
    localparam logic [2:0] S_WR_B    = 3'd3;
    localparam logic [2:0] S_WR_C    = 3'd4;
    localparam logic [2:0] S_RD      = 3'd5;
    localparam logic [2:0] S_RD_WAIT = 3'd6;
    localparam logic [2:0] S_FINISH  = 3'd7;

    localparam int              LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    logic [2:0]       state;
    logic [31:0]      acc;
    logic [31:0]      b_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] count_inc;
    logic [LAT_W-1:0] lat_cnt;

    assign count_inc  = count + LEN_W'(1);
    assign busy       = (state != S_IDLE);
    assign pair_ready = (state == S_LOAD);

    // Bus strobes, address and data are set up one state ahead so they leave
    // the block straight from flops and stay frozen while the slave stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            acc           <= '0;
            b_reg         <= '0;
            len_reg       <= '0;
            count         <= '0;
            lat_cnt       <= '0;
            result        <= '0;
            done          <= 1'b0;
            avm_address   <= '0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            avm_read      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc     <= bias;
                        len_reg <= len;
                        count   <= '0;
                        state   <= (len == '0) ? S_FINISH : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (pair_valid) begin
                        b_reg         <= pair_b;
                        avm_write     <= 1'b1;
                        avm_address   <= 2'd0;
                        avm_writedata <= pair_a;
                        state         <= S_WR_A;
                    end
                end
                S_WR_A: begin
                    if (!avm_waitrequest) begin
                        avm_address   <= 2'd1;
                        avm_writedata <= b_reg;
                        state         <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (!avm_waitrequest) begin
                        avm_address   <= 2'd2;
                        avm_writedata <= acc;
                        state         <= S_WR_C;
                    end
                end
                S_WR_C: begin
                    if (!avm_waitrequest) begin
                        avm_write     <= 1'b0;
                        avm_read      <= 1'b1;
                        avm_address   <= 2'd3;
                        avm_writedata <= '0;
                        state         <= S_RD;
                    end
                end
                S_RD: begin
                    if (!avm_waitrequest) begin
                        avm_read    <= 1'b0;
                        avm_address <= 2'd0;
                        lat_cnt     <= '0;
                        state       <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // readdata is only valid on the last latency cycle
                    if (lat_cnt == LAT_LAST) begin
                        acc   <= avm_readdata;
                        count <= count_inc;
                        state <= (count_inc == len_reg) ? S_FINISH : S_LOAD;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_FINISH: begin
                    result <= acc;
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mulacc_dot_master.sv
// Bench for mulacc_dot_master: three builds (RL=1, RL=2, LEN_W=3) each driving
// a behavioural fp32 MAC slave with programmable wait states.
module tb_mulacc_dot_master;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] reset_n, start, pair_valid, pair_ready, busy, done;
    logic [NI-1:0] avm_write, avm_read, waitreq;
    logic [15:0]   len_s  [NI];
    logic [31:0]   bias_s [NI];
    logic [31:0]   pa     [NI];
    logic [31:0]   pb     [NI];
    logic [31:0]   result [NI];
    logic [31:0]   wdata  [NI];
    logic [31:0]   rdata  [NI];
    logic [1:0]    addr   [NI];
    int            ws_b   [NI];
    int            ws_rd  [NI];
    int            n_wr   [NI];
    int            n_rd   [NI];
    int            stab_err [NI];
    int            both_err [NI];

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] i2f(input int i);
        return r2f(real'(i));
    endfunction

    function automatic logic [31:0] mac(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return r2f(f2r(a) * f2r(b) + f2r(c));
    endfunction

    function automatic int rl_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int RL = (g == 1) ? 2 : 1;
        localparam int LW = (g == 2) ? 3 : 16;

        mulacc_dot_master #(.LEN_W(LW), .READ_LATENCY(RL)) dut (
            .clk             (clk),
            .reset_n         (reset_n[g]),
            .start           (start[g]),
            .len             (len_s[g][LW-1:0]),
            .bias            (bias_s[g]),
            .pair_valid      (pair_valid[g]),
            .pair_ready      (pair_ready[g]),
            .pair_a          (pa[g]),
            .pair_b          (pb[g]),
            .busy            (busy[g]),
            .done            (done[g]),
            .result          (result[g]),
            .avm_address     (addr[g]),
            .avm_write       (avm_write[g]),
            .avm_writedata   (wdata[g]),
            .avm_read        (avm_read[g]),
            .avm_readdata    (rdata[g]),
            .avm_waitrequest (waitreq[g])
        );

        logic [31:0]   ra = '0, rb = '0, rc = '0;
        logic [31:0]   pd [RL];
        logic [RL-1:0] pv = '0;
        int            stall = 0, nw = 0, nr = 0, se = 0, be = 0;
        logic          hold_v = 1'b0, hold_w = 1'b0, hold_r = 1'b0;
        logic [1:0]    hold_a = '0;
        logic [31:0]   hold_d = '0;
        logic          req;
        int            lim;

        assign req   = avm_write[g] | avm_read[g];
        assign lim   = avm_read[g] ? ws_rd[g] : ((avm_write[g] && addr[g] == 2'd1) ? ws_b[g] : 0);
        assign waitreq[g] = req && (stall < lim);
        assign rdata[g]   = pv[RL-1] ? pd[RL-1] : 32'h7FC0_DEAD;
        assign n_wr[g]     = nw;
        assign n_rd[g]     = nr;
        assign stab_err[g] = se;
        assign both_err[g] = be;

        always @(posedge clk) begin
            if (req && waitreq[g]) stall <= stall + 1;
            else stall <= 0;
            if (avm_read[g] && avm_write[g]) be <= be + 1;
            if (hold_v && {avm_write[g], avm_read[g], addr[g], wdata[g]} !=
                          {hold_w, hold_r, hold_a, hold_d}) se <= se + 1;
            hold_v <= req && waitreq[g];
            hold_w <= avm_write[g];
            hold_r <= avm_read[g];
            hold_a <= addr[g];
            hold_d <= wdata[g];
            if (avm_write[g] && !waitreq[g]) begin
                nw <= nw + 1;
                case (addr[g])
                    2'd0: ra <= wdata[g];
                    2'd1: rb <= wdata[g];
                    2'd2: rc <= wdata[g];
                    default: ;
                endcase
            end
            if (avm_read[g] && !waitreq[g]) nr <= nr + 1;
            pv[0] <= avm_read[g] && !waitreq[g];
            pd[0] <= mac(ra, rb, rc);
            for (int i = 1; i < RL; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    logic [31:0] ja [8];
    logic [31:0] jb [8];

    task automatic run_job(input int k, input int ln, input logic [31:0] bs, input int abort_rd,
                           input bit poke, output logic [31:0] res, output int lat,
                           output int rdy, output bit got);
        int  idx = 0;
        int  rd0;
        bit  hs;
        res = '0; lat = 0; rdy = 0; got = 1'b0;
        rd0 = n_rd[k];
        @(negedge clk);
        start[k]      = 1'b1;
        len_s[k]      = 16'(ln);
        bias_s[k]     = bs;
        pair_valid[k] = (ln > 0);
        pa[k]         = ja[0];
        pb[k]         = jb[0];
        @(posedge clk);
        #1 start[k] = 1'b0;
        for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
            @(negedge clk);
            if (abort_rd > 0 && n_rd[k] - rd0 == abort_rd) begin
                #1 reset_n[k] = 1'b0;
                pair_valid[k] = 1'b0;
                return;
            end
            if (poke) begin
                start[k] = (cyc == 3);
                if (cyc == 3) begin
                    len_s[k]  = 16'd0;
                    bias_s[k] = 32'h4B00_0000;
                end
            end
            if (pair_ready[k]) rdy++;
            hs = pair_ready[k] & pair_valid[k];
            if (done[k]) begin
                got = 1'b1;
                res = result[k];
                lat = cyc + 1;
            end else begin
                @(posedge clk);
                #1;
                if (hs) begin
                    idx++;
                    if (idx < ln) begin
                        pa[k] = ja[idx];
                        pb[k] = jb[idx];
                    end else begin
                        pair_valid[k] = 1'b0;
                    end
                end
            end
        end
        start[k] = 1'b0;
    endtask

    task automatic do_job(input string nm, input int k, input int ln, input logic [31:0] bs,
                          input int wsb, input int wsrd, input bit poke, input logic [31:0] exp);
        logic [31:0] res;
        int lat, rdy, w0, r0;
        bit got;
        ws_b[k]  = wsb;
        ws_rd[k] = wsrd;
        w0 = n_wr[k];
        r0 = n_rd[k];
        run_job(k, ln, bs, 0, poke, res, lat, rdy, got);
        check({nm, " done"}, 32'(got), 32'd1);
        check({nm, " result"}, res, exp);
        check({nm, " latency"}, 32'(lat), 32'(2 + ln * (5 + rl_of(k)) + ln * (wsb + wsrd)));
        check({nm, " ready_cycles"}, 32'(rdy), 32'(ln));
        check({nm, " writes"}, 32'(n_wr[k] - w0), 32'(3 * ln));
        check({nm, " reads"}, 32'(n_rd[k] - r0), 32'(ln));
        check({nm, " busy_after"}, 32'(busy[k]), 32'd0);
    endtask

    typedef struct {
        int              k;
        int              ln;
        logic [31:0]     bs;
        int              wsb;
        int              wsrd;
        bit              poke;
        logic [7:0][31:0] a;
        logic [7:0][31:0] b;
        logic [31:0]     exp;
    } vec_t;

    vec_t vt [7];

    task automatic set_vec(input int i, input int k, input int ln, input logic [31:0] bs,
                           input int wsb, input int wsrd, input bit poke, input logic [31:0] exp);
        vt[i].k = k; vt[i].ln = ln; vt[i].bs = bs; vt[i].wsb = wsb; vt[i].wsrd = wsrd;
        vt[i].poke = poke; vt[i].exp = exp; vt[i].a = '0; vt[i].b = '0;
    endtask

    initial begin
        int sum, bi, av, bv, k, ln;
        logic [31:0] res;
        int lat, rdy, dcnt;
        bit got;

        reset_n = '0; start = '0; pair_valid = '0;
        for (int i = 0; i < NI; i++) begin
            len_s[i] = '0; bias_s[i] = '0; pa[i] = '0; pb[i] = '0; ws_b[i] = 0; ws_rd[i] = 0;
        end
        #12;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset busy%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("reset strobes%0d", i),
                  32'({avm_write[i], avm_read[i], done[i], pair_ready[i]}), 32'd0);
            check($sformatf("reset result%0d", i), result[i], 32'd0);
        end
        @(negedge clk);
        reset_n = '1;

        set_vec(0, 0, 1, 32'h3F80_0000, 0, 0, 1'b0, 32'h40E0_0000);
        vt[0].a[0] = 32'h4000_0000; vt[0].b[0] = 32'h4040_0000;
        set_vec(1, 0, 3, 32'h0000_0000, 0, 0, 1'b0, 32'h4040_0000);
        for (int j = 0; j < 3; j++) begin vt[1].a[j] = 32'h3F80_0000; vt[1].b[j] = 32'h3F80_0000; end
        set_vec(2, 0, 0, 32'hC0A0_0000, 0, 0, 1'b0, 32'hC0A0_0000);
        set_vec(3, 0, 1, 32'h3F80_0000, 3, 3, 1'b0, 32'h40E0_0000);
        vt[3].a[0] = 32'h4000_0000; vt[3].b[0] = 32'h4040_0000;
        set_vec(4, 1, 2, 32'h4000_0000, 0, 0, 1'b0, 32'h41E0_0000);
        vt[4].a[0] = 32'h4000_0000; vt[4].b[0] = 32'h4040_0000;
        vt[4].a[1] = 32'h4080_0000; vt[4].b[1] = 32'h40A0_0000;
        set_vec(5, 2, 7, 32'h0000_0000, 0, 0, 1'b1, 32'h40E0_0000);
        for (int j = 0; j < 7; j++) begin vt[5].a[j] = 32'h3F80_0000; vt[5].b[j] = 32'h3F80_0000; end
        set_vec(6, 1, 1, 32'h3F80_0000, 2, 1, 1'b0, 32'h40E0_0000);
        vt[6].a[0] = 32'h4000_0000; vt[6].b[0] = 32'h4040_0000;

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 8; j++) begin ja[j] = vt[i].a[j]; jb[j] = vt[i].b[j]; end
            do_job($sformatf("vec%0d", i), vt[i].k, vt[i].ln, vt[i].bs, vt[i].wsb, vt[i].wsrd,
                   vt[i].poke, vt[i].exp);
        end

        // Randomized jobs against an integer dot-product model.
        for (int t = 0; t < 12; t++) begin
            k   = int'($urandom_range(0, NI - 1));
            ln  = int'($urandom_range(1, (k == 2) ? 7 : 6));
            bi  = int'($urandom_range(0, 40)) - 20;
            sum = bi;
            for (int j = 0; j < ln; j++) begin
                av = int'($urandom_range(0, 12)) - 6;
                bv = int'($urandom_range(0, 12)) - 6;
                ja[j] = i2f(av);
                jb[j] = i2f(bv);
                sum += av * bv;
            end
            do_job($sformatf("rand%0d", t), k, ln, i2f(bi), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), i2f(sum));
        end

        // Reset in RD_WAIT of pair 2 of 4, then a fresh job.
        ws_b[0] = 0; ws_rd[0] = 0;
        for (int j = 0; j < 4; j++) begin ja[j] = 32'h3F80_0000; jb[j] = 32'h4000_0000; end
        run_job(0, 4, 32'h0000_0000, 2, 1'b0, res, lat, rdy, got);
        #1;
        check("midreset busy", 32'(busy[0]), 32'd0);
        check("midreset strobes", 32'({avm_write[0], avm_read[0], pair_ready[0], done[0]}), 32'd0);
        check("midreset addr_data", {wdata[0][29:0], addr[0]}, 32'd0);
        check("midreset result", result[0], 32'd0);
        dcnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done[0]) dcnt++;
        end
        reset_n[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done[0]) dcnt++;
        end
        check("midreset no_done", 32'(dcnt), 32'd0);
        ja[0] = 32'h4040_0000; jb[0] = 32'h4080_0000;
        do_job("after_reset", 0, 1, 32'hBF80_0000, 0, 0, 1'b0, i2f(11));

        for (int i = 0; i < NI; i++) begin
            check($sformatf("stable_during_wait%0d", i), 32'(stab_err[i]), 32'd0);
            check($sformatf("no_rd_wr_overlap%0d", i), 32'(both_err[i]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
